io_ctrl: RTL and testbench
==========================

IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_w_req  input  1  CPU write-byte request, one byte per asserted cycle.
REQ-005 SHALL have port cpu_w_data  input  8  byte accompanying cpu_w_req.
REQ-006 SHALL have port cpu_w_busy  output  1  TX FIFO full.
REQ-007 SHALL have port cpu_r_data  output  8  last received byte.
REQ-008 SHALL have port cpu_ack  input  1  CPU acknowledges RX interrupt.
REQ-009 SHALL have port cpu_intr_req  output  1  RX byte pending.
REQ-010 SHALL have port tx_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 SHALL have port tx_data  output  8  byte for transmitter, valid while tx_start=1.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy.
REQ-013 SHALL have port rx_valid  input  1  one-cycle strobe from the UART receiver.
REQ-014 SHALL have port rx_data  input  8  received byte, valid with rx_valid.
REQ-015 SHALL have port rx_overrun  output  1  sticky: byte received while previous one still pending.

Function
REQ-016 SHALL push cpu_w_data into the TX FIFO when cpu_w_req=1 and count<TX_DEPTH; count updates at the next edge.
REQ-017 SHALL drop a write when count==TX_DEPTH, even if a pop occurs in the same cycle.
REQ-018 SHALL leave count unchanged on a simultaneous push and pop when not full.
REQ-019 SHALL drive cpu_w_busy combinationally as (count==TX_DEPTH).
REQ-020 SHALL wrap read/write pointers modulo TX_DEPTH using a count of width clog2(TX_DEPTH)+1.
REQ-021 SHALL implement TX FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-022 SHALL move IDLE->START when count>0 and tx_busy=0; otherwise remain in IDLE.
REQ-023 SHALL, in START, assert tx_start=1 with tx_data=FIFO head, pop the head, and move to WAIT_BUSY.
REQ-024 SHALL move WAIT_BUSY->WAIT_DONE when tx_busy=1; the transmitter guarantees busy within 1 cycle of tx_start.
REQ-025 SHALL move WAIT_DONE->IDLE when tx_busy=0.
REQ-026 SHALL give a first tx_start 2 cycles after the accepting push edge into an empty, idle FIFO.
REQ-027 SHALL drive tx_start=0 and tx_data=8'd0 outside START.
REQ-028 SHALL, on rx_valid=1, load cpu_r_data<=rx_data and set the pending flag.
REQ-029 SHALL set rx_overrun when rx_valid=1 while pending=1 and cpu_ack=0.
REQ-030 SHALL clear pending and rx_overrun on cpu_ack=1 without rx_valid.
REQ-031 SHALL, on simultaneous rx_valid and cpu_ack, load the new byte, keep pending=1, and leave rx_overrun unchanged.
REQ-032 SHALL drive cpu_intr_req directly from the registered pending flag.

Reset
REQ-033 SHALL, while reset=1, asynchronously force FSM=IDLE, pointers=0, count=0, cpu_r_data=8'd0, pending=0, rx_overrun=0.
REQ-034 SHALL make reset mid-transmission discard FIFO contents, emit no further tx_start, and wait in IDLE until tx_busy=0 before the next start.

Structure
REQ-035 SHALL place the TX state enum typedef and the default TX_DEPTH constant in shared package lib_io.
REQ-036 SHALL implement the FIFO storage, pointers and count as sub-module io_fifo (push/pop/full/empty/head); io_ctrl holds the FSM and RX logic.

Verification
REQ-037 SHALL verify single byte: push 8'h41 into an idle FIFO with tx_busy=0 -> tx_start=1 with tx_data=8'h41 exactly 2 cycles later, for one cycle.
REQ-038 SHALL verify full: with tx_busy held at 1, push 8'h01..8'h05 -> cpu_w_busy=1 after the 4th push, 8'h05 dropped; release busy -> transmitted bytes are 01,02,03,04 in order.
REQ-039 SHALL verify wrap-around: 10 bytes 8'h10..8'h19 streamed with a transmitter model -> all 10 transmitted in order, no duplicates.
REQ-040 SHALL verify RX: rx_valid with 8'h5A -> cpu_intr_req=1 and cpu_r_data=8'h5A next cycle; cpu_ack -> cpu_intr_req=0.
REQ-041 SHALL verify overrun and collision: two rx_valid pulses 8'h11, 8'h22 without ack -> cpu_r_data=8'h22, rx_overrun=1; rx_valid with ack in the same cycle -> pending=1, rx_overrun unchanged.
REQ-042 SHALL verify reset in WAIT_DONE with 3 bytes queued -> count=0, no tx_start after deassertion, until a new push.

Source files
------------

// File: rtl/lib_io.sv
// Shared types and defaults for the CPU-side UART I/O controller.
package lib_io;
    localparam int TX_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;
endpackage

// File: rtl/io_fifo.sv
// Byte FIFO for the TX path: power-of-two depth, pointers wrap naturally.
module io_fifo
    import lib_io::*;
#(
    parameter int DEPTH = TX_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/io_ctrl.sv
// CPU <-> UART glue: TX byte FIFO with start/busy handshake, single-byte RX
// holding register with interrupt and sticky overrun.
module io_ctrl
    import lib_io::*;
#(
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_w_req,
    input  logic [7:0] cpu_w_data,
    output logic       cpu_w_busy,
    output logic [7:0] cpu_r_data,
    input  logic       cpu_ack,
    output logic       cpu_intr_req,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_overrun
);
    tx_state_e  state_q, state_d;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_head;
    logic [7:0] r_data_q, r_data_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;

    io_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (cpu_w_req),
        .din   (cpu_w_data),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign cpu_w_busy = fifo_full;
    assign fifo_pop   = (state_q == START);
    assign tx_start   = (state_q == START);
    assign tx_data    = (state_q == START) ? fifo_head : 8'd0;

    // IDLE also waits out a transmitter still busy from before a reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!fifo_empty && !tx_busy) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // An ack colliding with a new byte consumes the old one; overrun is left alone.
    always_comb begin
        r_data_d  = r_data_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (rx_valid) begin
            r_data_d  = rx_data;
            pending_d = 1'b1;
            if (pending_q && !cpu_ack) overrun_d = 1'b1;
        end else if (cpu_ack) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            r_data_q  <= 8'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_data_q  <= r_data_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign cpu_r_data   = r_data_q;
    assign cpu_intr_req = pending_q;
    assign rx_overrun   = overrun_q;
endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: queue/rule model checked every cycle plus directed scenarios.
module tb_io_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_w_req = 1'b0;
    logic [7:0] cpu_w_data = 8'd0;
    logic       cpu_w_busy;
    logic [7:0] cpu_r_data;
    logic       cpu_ack = 1'b0;
    logic       cpu_intr_req;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_overrun;

    logic auto_tx = 1'b1;
    logic force_busy = 1'b0;
    int   busy_cnt = 0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] exp_rd = 8'd0;
    logic       exp_pend = 1'b0;
    logic       exp_ovr = 1'b0;

    io_ctrl #(.TX_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_w_req    (cpu_w_req),
        .cpu_w_data   (cpu_w_data),
        .cpu_w_busy   (cpu_w_busy),
        .cpu_r_data   (cpu_r_data),
        .cpu_ack      (cpu_ack),
        .cpu_intr_req (cpu_intr_req),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: busy for three cycles after each start strobe.
    assign tx_busy = auto_tx ? (busy_cnt > 0) : force_busy;
    always @(negedge clk) begin
        if (auto_tx && tx_start) busy_cnt = 3;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model: outputs now reflect state after the last edge; then fold in
    // this cycle's inputs, which take effect at the coming edge.
    always @(negedge clk) begin
        logic was_full;
        if (reset) begin
            mq.delete();
            exp_rd = 8'd0; exp_pend = 1'b0; exp_ovr = 1'b0;
            chk("rst_tx_start", tx_start, 0);
            chk("rst_w_busy", cpu_w_busy, 0);
            chk("rst_intr", cpu_intr_req, 0);
            chk("rst_r_data", cpu_r_data, 0);
            chk("rst_overrun", rx_overrun, 0);
        end else begin
            chk("m_w_busy", cpu_w_busy, (mq.size() == DEPTH));
            chk("m_intr", cpu_intr_req, exp_pend);
            chk("m_r_data", cpu_r_data, exp_rd);
            chk("m_overrun", rx_overrun, exp_ovr);
            was_full = (mq.size() == DEPTH);
            if (tx_start) begin
                chk("m_start_nonempty", (mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    chk("m_tx_data", tx_data, mq[0]);
                    void'(mq.pop_front());
                end
                sent.push_back(tx_data);
            end else begin
                chk("m_tx_data_idle", tx_data, 0);
            end
            if (cpu_w_req && !was_full) mq.push_back(cpu_w_data);
            if (rx_valid) begin
                if (exp_pend && !cpu_ack) exp_ovr = 1'b1;
                exp_rd = rx_data;
                exp_pend = 1'b1;
            end else if (cpu_ack) begin
                exp_pend = 1'b0;
                exp_ovr = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        cpu_w_req = 1'b1;
        cpu_w_data = b;
        cyc();
        cpu_w_req = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int bound, input string name);
        int k = 0;
        while (sent.size() < n && k < bound) begin
            cyc();
            k++;
        end
        chk(name, sent.size(), n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        repeat (3) cyc();

        // Single byte: start strobe in the second cycle after the push cycle.
        push(8'h41);
        @(negedge clk); chk("t1_no_start_yet", tx_start, 0);
        cyc();
        @(negedge clk); chk("t1_start", tx_start, 1); chk("t1_data", tx_data, 8'h41);
        cyc();
        @(negedge clk); chk("t1_start_one_cycle", tx_start, 0);
        repeat (8) cyc();

        // Full FIFO while the transmitter is held busy.
        sent.delete();
        auto_tx = 1'b0; force_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        @(negedge clk); chk("t2_full", cpu_w_busy, 1);
        push(8'h05);
        auto_tx = 1'b1;
        wait_sent(4, 100, "t2_sent_cnt");
        for (int i = 0; i < 4 && i < sent.size(); i++) chk("t2_order", sent[i], 8'(i + 1));
        repeat (10) cyc();
        chk("t2_no_fifth", sent.size(), 4);

        // Wrap-around streaming.
        sent.delete();
        for (int i = 0; i < 10; i++) begin
            while (cpu_w_busy) cyc();
            push(8'h10 + 8'(i));
        end
        wait_sent(10, 300, "t3_sent_cnt");
        for (int i = 0; i < 10 && i < sent.size(); i++) chk("t3_order", sent[i], 8'h10 + 8'(i));
        repeat (10) cyc();
        chk("t3_no_dup", sent.size(), 10);

        // RX single byte and ack.
        rx_valid = 1'b1; rx_data = 8'h5A; cyc(); rx_valid = 1'b0;
        @(negedge clk); chk("t4_intr", cpu_intr_req, 1); chk("t4_data", cpu_r_data, 8'h5A);
        cpu_ack = 1'b1; cyc(); cpu_ack = 1'b0;
        @(negedge clk); chk("t4_intr_clr", cpu_intr_req, 0);

        // Overrun, then collision of new byte with ack.
        rx_valid = 1'b1; rx_data = 8'h11; cyc();
        rx_data = 8'h22; cyc(); rx_valid = 1'b0;
        @(negedge clk); chk("t5_data", cpu_r_data, 8'h22); chk("t5_ovr", rx_overrun, 1);
        rx_valid = 1'b1; rx_data = 8'h33; cpu_ack = 1'b1; cyc();
        rx_valid = 1'b0; cpu_ack = 1'b0;
        @(negedge clk);
        chk("t5_coll_pend", cpu_intr_req, 1); chk("t5_coll_ovr", rx_overrun, 1);
        chk("t5_coll_data", cpu_r_data, 8'h33);
        cpu_ack = 1'b1; cyc(); cpu_ack = 1'b0;
        @(negedge clk); chk("t5_ack_pend", cpu_intr_req, 0); chk("t5_ack_ovr", rx_overrun, 0);

        // Reset in WAIT_DONE with three bytes still queued.
        sent.delete();
        auto_tx = 1'b0; force_busy = 1'b1;
        repeat (3) cyc();
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        @(negedge clk); chk("t6_full", cpu_w_busy, 1);
        force_busy = 1'b0;
        cyc();
        force_busy = 1'b1;
        cyc(); cyc();
        chk("t6_first_sent", sent.size(), 1);
        reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        repeat (3) cyc();
        force_busy = 1'b0;
        repeat (10) cyc();
        chk("t6_no_start", sent.size(), 1);
        @(negedge clk); chk("t6_empty", cpu_w_busy, 0);
        auto_tx = 1'b1;
        push(8'hB7);
        wait_sent(2, 50, "t6_new_sent");
        if (sent.size() >= 2) chk("t6_new_data", sent[1], 8'hB7);
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
